// File: rtl/vga_timing_pkg.sv
// Shared raster geometry for the VGA timing generator and the colour stage.
// Holds the default 640x480@60 constants and the line/frame length helpers.
package vga_timing_pkg;

   localparam int COORD_W   = 10;
   localparam int MAX_TOTAL = 1 << COORD_W;

   localparam int DEF_H_DISP = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_DISP = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;

   // Unencoded (active-high) raster flags before sync polarity is applied.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_on;
   } raster_flags_t;

   function automatic int h_total(input int disp, input int fp, input int sync, input int bp);
      return disp + fp + sync + bp;
   endfunction

   function automatic int v_total(input int disp, input int fp, input int sync, input int bp);
      return disp + fp + sync + bp;
   endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Pixel strobe divider: one-clock p_tick every DIV system clocks.
// p_tick decodes the counter register only, so it cannot glitch.
module pix_tick_div #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic p_tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] div_cnt;

   // With DIV=1 the counter sits at 0 == CNT_LAST, so p_tick is constantly high.
   always_ff @(posedge clk) begin
      if (!rst_n || (div_cnt == CNT_LAST)) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
      end
   end

   assign p_tick = (div_cnt == CNT_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, x/y counters and registered
// sync/blanking/strobe outputs aligned with the visible pixel coordinates.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISP   = DEF_H_DISP,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_DISP   = DEF_V_DISP,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int DIV      = 2,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic               clk_50MHz,
   input  logic               rst_n,
   output logic               p_tick,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               line_tick,
   output logic               frame_tick
);

   localparam int H_TOTAL  = h_total(H_DISP, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL  = v_total(V_DISP, V_FP, V_SYNC, V_BP);
   localparam int HS_START = H_DISP + H_FP;
   localparam int HS_END   = H_DISP + H_FP + H_SYNC - 1;
   localparam int VS_START = V_DISP + V_FP;
   localparam int VS_END   = V_DISP + V_FP + V_SYNC - 1;

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOTAL - 1);

   if ((H_TOTAL > MAX_TOTAL) || (V_TOTAL > MAX_TOTAL) || (DIV < 1)) begin : g_bad_config
      $error("vga_timing_gen: line/frame length exceeds coordinate range or DIV < 1");
   end

   logic               x_wrap;
   logic               y_wrap;
   logic [COORD_W-1:0] next_x;
   logic [COORD_W-1:0] next_y;
   raster_flags_t      next_flags;

   function automatic raster_flags_t decode(input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y);
      raster_flags_t f;
      f.hsync    = (int'(x) >= HS_START) && (int'(x) <= HS_END);
      f.vsync    = (int'(y) >= VS_START) && (int'(y) <= VS_END);
      f.video_on = (int'(x) < H_DISP) && (int'(y) < V_DISP);
      return f;
   endfunction

   pix_tick_div #(
      .DIV (DIV)
   ) u_tick_div (
      .clk    (clk_50MHz),
      .rst_n  (rst_n),
      .p_tick (p_tick)
   );

   // Outputs are registered from the next-count values so they line up with pixel_x/pixel_y.
   always_comb begin
      x_wrap     = (pixel_x == X_LAST);
      y_wrap     = (pixel_y == Y_LAST);
      next_x     = pixel_x;
      next_y     = pixel_y;
      if (p_tick) begin
         next_x = x_wrap ? '0 : pixel_x + COORD_W'(1);
         if (x_wrap) begin
            next_y = y_wrap ? '0 : pixel_y + COORD_W'(1);
         end
      end
      next_flags = decode(next_x, next_y);
   end

   // Reset parks the counters on the last blanking pixel so the first p_tick lands on (0,0).
   always_ff @(posedge clk_50MHz) begin
      if (!rst_n) begin
         pixel_x    <= X_LAST;
         pixel_y    <= Y_LAST;
         hsync      <= ~SYNC_POL;
         vsync      <= ~SYNC_POL;
         video_on   <= 1'b0;
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         pixel_x    <= next_x;
         pixel_y    <= next_y;
         hsync      <= next_flags.hsync ? SYNC_POL : ~SYNC_POL;
         vsync      <= next_flags.vsync ? SYNC_POL : ~SYNC_POL;
         video_on   <= next_flags.video_on;
         line_tick  <= p_tick && x_wrap;
         frame_tick <= p_tick && x_wrap && y_wrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus two small geometries,
// all checked each cycle against an arithmetic raster model.
module tb_vga_timing_gen;

   typedef struct packed {
      int hd; int hf; int hs; int hb;
      int vd; int vf; int vs; int vb;
      int dv; bit pol;
   } geom_t;

   typedef struct {
      bit p_tick; bit hsync; bit vsync; bit video_on; bit line_tick; bit frame_tick;
      int x; int y;
   } ref_t;

   typedef struct {
      bit rst_n;
      bit p_tick; int x; int y;
      bit hsync; bit vsync; bit video_on; bit line_tick; bit frame_tick;
   } vec_t;

   localparam geom_t GA = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b1};
   localparam geom_t GB = '{8, 2, 3, 3, 4, 1, 1, 1, 1, 1'b0};
   localparam geom_t GC = '{4, 2, 3, 1, 3, 1, 2, 2, 3, 1'b1};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   longint     t = 0;
   int         total = 0;
   int         bad = 0;

   logic       a_p, a_h, a_v, a_vid, a_lt, a_ft;
   logic [9:0] a_x, a_y;
   logic       b_p, b_h, b_v, b_vid, b_lt, b_ft;
   logic [9:0] b_x, b_y;
   logic       c_p, c_h, c_v, c_vid, c_lt, c_ft;
   logic [9:0] c_x, c_y;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_DISP(GA.hd), .H_FP(GA.hf), .H_SYNC(GA.hs), .H_BP(GA.hb),
      .V_DISP(GA.vd), .V_FP(GA.vf), .V_SYNC(GA.vs), .V_BP(GA.vb),
      .DIV(GA.dv), .SYNC_POL(GA.pol)
   ) dut_a (
      .clk_50MHz(clk), .rst_n(rst_n), .p_tick(a_p), .hsync(a_h), .vsync(a_v),
      .video_on(a_vid), .pixel_x(a_x), .pixel_y(a_y), .line_tick(a_lt), .frame_tick(a_ft)
   );

   vga_timing_gen #(
      .H_DISP(GB.hd), .H_FP(GB.hf), .H_SYNC(GB.hs), .H_BP(GB.hb),
      .V_DISP(GB.vd), .V_FP(GB.vf), .V_SYNC(GB.vs), .V_BP(GB.vb),
      .DIV(GB.dv), .SYNC_POL(GB.pol)
   ) dut_b (
      .clk_50MHz(clk), .rst_n(rst_n), .p_tick(b_p), .hsync(b_h), .vsync(b_v),
      .video_on(b_vid), .pixel_x(b_x), .pixel_y(b_y), .line_tick(b_lt), .frame_tick(b_ft)
   );

   vga_timing_gen #(
      .H_DISP(GC.hd), .H_FP(GC.hf), .H_SYNC(GC.hs), .H_BP(GC.hb),
      .V_DISP(GC.vd), .V_FP(GC.vf), .V_SYNC(GC.vs), .V_BP(GC.vb),
      .DIV(GC.dv), .SYNC_POL(GC.pol)
   ) dut_c (
      .clk_50MHz(clk), .rst_n(rst_n), .p_tick(c_p), .hsync(c_h), .vsync(c_v),
      .video_on(c_vid), .pixel_x(c_x), .pixel_y(c_y), .line_tick(c_lt), .frame_tick(c_ft)
   );

   // t counts clock edges since reset was released; position is linear pixel index mod frame size.
   function automatic ref_t ref_model(input geom_t g, input longint tt);
      ref_t   r;
      longint htot, vtot, tot, adv, pos;
      bit     hs_on, vs_on;
      htot  = g.hd + g.hf + g.hs + g.hb;
      vtot  = g.vd + g.vf + g.vs + g.vb;
      tot   = htot * vtot;
      adv   = tt / g.dv;
      pos   = (tot - 1 + adv) % tot;
      r.x   = int'(pos % htot);
      r.y   = int'(pos / htot);
      r.p_tick = ((tt % g.dv) == g.dv - 1);
      hs_on = (tt > 0) && (r.x >= g.hd + g.hf) && (r.x <= g.hd + g.hf + g.hs - 1);
      vs_on = (tt > 0) && (r.y >= g.vd + g.vf) && (r.y <= g.vd + g.vf + g.vs - 1);
      r.hsync      = hs_on ? g.pol : !g.pol;
      r.vsync      = vs_on ? g.pol : !g.pol;
      r.video_on   = (tt > 0) && (r.x < g.hd) && (r.y < g.vd);
      r.line_tick  = (adv > 0) && ((tt % g.dv) == 0) && (r.x == 0);
      r.frame_tick = r.line_tick && (r.y == 0);
      return r;
   endfunction

   task automatic check_one(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d required=%0d (t=%0d)", nm, act, exp, t);
      end
   endtask

   task automatic compare_dut(input string tag, input ref_t r,
                              input bit p, input bit h, input bit v, input bit vid,
                              input bit lt, input bit ft, input int x, input int y);
      check_one({tag, ".p_tick"}, int'(p), int'(r.p_tick));
      check_one({tag, ".hsync"}, int'(h), int'(r.hsync));
      check_one({tag, ".vsync"}, int'(v), int'(r.vsync));
      check_one({tag, ".video_on"}, int'(vid), int'(r.video_on));
      check_one({tag, ".line_tick"}, int'(lt), int'(r.line_tick));
      check_one({tag, ".frame_tick"}, int'(ft), int'(r.frame_tick));
      check_one({tag, ".pixel_x"}, x, r.x);
      check_one({tag, ".pixel_y"}, y, r.y);
   endtask

   task automatic check_output();
      compare_dut("A", ref_model(GA, t), a_p, a_h, a_v, a_vid, a_lt, a_ft, int'(a_x), int'(a_y));
      compare_dut("B", ref_model(GB, t), b_p, b_h, b_v, b_vid, b_lt, b_ft, int'(b_x), int'(b_y));
      compare_dut("C", ref_model(GC, t), c_p, c_h, c_v, c_vid, c_lt, c_ft, int'(c_x), int'(c_y));
   endtask

   // One clock: drive reset level, advance the model on the edge, check on the falling edge.
   task automatic apply_stimulus(input bit r);
      rst_n = r;
      @(posedge clk);
      if (r) t++;
      else   t = 0;
      @(negedge clk);
      check_output();
   endtask

   task automatic measure_frame(input string nm, input int expected, input bit use_b);
      int  gap;
      bit  seen;
      bit  ft;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         apply_stimulus(1'b1);
         ft = use_b ? b_ft : c_ft;
         if (ft) seen = 1'b1;
      end
      check_one({nm, ".first_frame_seen"}, int'(seen), 1);
      gap  = 0;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         apply_stimulus(1'b1);
         gap++;
         ft = use_b ? b_ft : c_ft;
         if (ft) seen = 1'b1;
      end
      check_one({nm, ".frame_period"}, gap, expected);
   endtask

   vec_t vecs[10];

   initial begin
      int  cnt, dbl, hs_cnt, vid_low, lt_cnt;
      bit  prev, found;

      for (int i = 0; i < 5; i++) vecs[i] = '{0, 0, 799, 524, 0, 0, 0, 0, 0};
      vecs[5] = '{1, 1, 799, 524, 0, 0, 0, 0, 0};
      vecs[6] = '{1, 0, 0,   0,   0, 0, 1, 1, 1};
      vecs[7] = '{1, 1, 0,   0,   0, 0, 1, 0, 0};
      vecs[8] = '{1, 0, 1,   0,   0, 0, 1, 0, 0};
      vecs[9] = '{1, 1, 1,   0,   0, 0, 1, 0, 0};

      $display("[TB] start-up table");
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(vecs[i].rst_n);
         check_one("tbl.p_tick", int'(a_p), int'(vecs[i].p_tick));
         check_one("tbl.pixel_x", int'(a_x), vecs[i].x);
         check_one("tbl.pixel_y", int'(a_y), vecs[i].y);
         check_one("tbl.hsync", int'(a_h), int'(vecs[i].hsync));
         check_one("tbl.vsync", int'(a_v), int'(vecs[i].vsync));
         check_one("tbl.video_on", int'(a_vid), int'(vecs[i].video_on));
         check_one("tbl.line_tick", int'(a_lt), int'(vecs[i].line_tick));
         check_one("tbl.frame_tick", int'(a_ft), int'(vecs[i].frame_tick));
      end

      $display("[TB] pixel tick rate");
      cnt  = 0;
      dbl  = 0;
      prev = a_p;
      for (int i = 0; i < 1000; i++) begin
         apply_stimulus(1'b1);
         if (a_p) cnt++;
         if (a_p && prev) dbl++;
         prev = a_p;
      end
      check_one("rate.p_tick_count", cnt, 500);
      check_one("rate.p_tick_wide", dbl, 0);

      $display("[TB] one line of horizontal timing");
      hs_cnt  = 0;
      vid_low = 0;
      lt_cnt  = 0;
      for (int i = 0; i < 1600; i++) begin
         apply_stimulus(1'b1);
         if (a_h) hs_cnt++;
         if (!a_vid) vid_low++;
         if (a_lt) lt_cnt++;
      end
      check_one("line.hsync_clks", hs_cnt, 192);
      check_one("line.blank_clks", vid_low, 320);
      check_one("line.line_ticks", lt_cnt, 1);

      $display("[TB] mid-line reset");
      found = 1'b0;
      for (int i = 0; i < 1700 && !found; i++) begin
         apply_stimulus(1'b1);
         if (a_x == 10'd300) found = 1'b1;
      end
      check_one("midreset.reach_x300", int'(found), 1);
      apply_stimulus(1'b0);
      check_one("midreset.pixel_x", int'(a_x), 799);
      check_one("midreset.pixel_y", int'(a_y), 524);
      check_one("midreset.video_on", int'(a_vid), 0);
      apply_stimulus(1'b1);
      check_one("midreset.p_tick", int'(a_p), 1);
      apply_stimulus(1'b1);
      check_one("midreset.restart_x", int'(a_x), 0);
      check_one("midreset.restart_y", int'(a_y), 0);
      check_one("midreset.restart_frame", int'(a_ft), 1);

      $display("[TB] small-geometry frame periods");
      measure_frame("B", 112, 1'b1);
      measure_frame("C", 240, 1'b0);

      $display("[TB] randomized reset/run sequences");
      for (int it = 0; it < 12; it++) begin
         int run_len, rst_len;
         run_len = int'($urandom_range(1, 2500));
         rst_len = int'($urandom_range(1, 3));
         for (int i = 0; i < rst_len; i++) apply_stimulus(1'b0);
         for (int i = 0; i < run_len; i++) apply_stimulus(1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
